// File: rtl/nano_loader_pkg.sv
// Shared types and constants for the imem_loader boot memory.
// State encoding, frame field widths and the default fetch filler word.
package nano_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } state_e;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANE_W = 2;
    localparam int CNT_W  = 8;

    localparam logic [WORD_W-1:0] NOP_WORD_DEF = 32'h0000_0013;

endpackage

// File: rtl/loader_ram.sv
// DEPTH x 32 instruction store: one synchronous write port, one async read port.
// Contents are intentionally not reset so a reload only touches written words.
module loader_ram
    import nano_loader_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Boot loader + instruction memory: unpacks a framed byte stream, then serves fetches.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import nano_loader_pkg::*;
#(
    parameter int                DEPTH    = 32,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic [31:0]       i_addr_i,
    input  logic              i_rd_i,
    output logic [WORD_W-1:0] i_data_o,
    output logic              core_rst_n_o,
    output logic              load_done_o,
    output logic              err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = AW + 1;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [23:0]       stage_q, stage_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    logic              accept;
    logic              we;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              unused_fetch;

    assign rx_ready_o = (state_q == IDLE) || (state_q == LOAD) ||
                        (state_q == CHECK);
    assign accept     = rx_valid_i && rx_ready_o;
    assign wdata      = {rx_data_i, stage_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rx_data_i == '0 || int'(rx_data_i) > DEPTH) begin
                        state_d = ERROR;
                    end else begin
                        state_d = LOAD;
                        idx_d   = '0;
                        lane_d  = '0;
                        cnt_d   = rx_data_i;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
            end
            LOAD: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data_i;
`endif
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: stage_d[7:0]   = rx_data_i;
                        2'd1: stage_d[15:8]  = rx_data_i;
                        2'd2: stage_d[23:16] = rx_data_i;
                        default: begin
                            we    = 1'b1;
                            idx_d = idx_q + 1'b1;
                            if (int'(idx_q) == int'(cnt_q) - 1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = CHECK;
`else
                                state_d = RUN;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_d = (rx_data_i == csum_q) ? RUN : ERROR;
                end
            end
`endif
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
        done_d = (state_d == RUN);
        err_d  = (state_d == ERROR);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lane_q  <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    loader_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (we),
        .waddr_i(idx_q[AW-1:0]),
        .wdata_i(wdata),
        .raddr_i(i_addr_i[AW+1:2]),
        .rdata_o(rdata)
    );

    // Fetch strobe and byte offset carry no information for a word-wide read.
    assign unused_fetch = ^{i_rd_i, i_addr_i[1:0]};

    assign i_data_o     = (int'(i_addr_i[31:2]) < DEPTH &&
                           i_addr_i[31] == 1'b0) ? rdata : NOP_WORD;
    assign core_rst_n_o = done_q;
    assign load_done_o  = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, random frames, corner sequences.
// Honours IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] i_addr = '0;
    logic        i_rd = 1'b1;
    logic [31:0] i_data;
    logic        core_rst_n;
    logic        load_done;
    logic        err;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready),
        .i_addr_i    (i_addr),
        .i_rd_i      (i_rd),
        .i_data_o    (i_data),
        .core_rst_n_o(core_rst_n),
        .load_done_o (load_done),
        .err_o       (err)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];
    logic [7:0]  fq [$];

    typedef struct {
        int n;
        bit exp_err;
        bit exp_done;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic push(logic [7:0] b, bit stall);
        if (stall) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Frame builder: count byte, data, optional XOR byte; commits model words.
    task automatic build(int n);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        fq.delete();
        fq.push_back(8'(n));
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                fq.push_back(b);
                x = x ^ b;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            fq.push_back(x);
`endif
            for (int k = 0; k < n; k++) begin
                model[k] = {fq[4*k+4], fq[4*k+3], fq[4*k+2], fq[4*k+1]};
                known[k] = 1'b1;
            end
        end
    endtask

    task automatic send_all(int mode);
        for (int i = 0; i < fq.size(); i++) begin
            push(fq[i], mode == 1 ? 1'b1 : (mode == 2 ? 1'($urandom) : 1'b0));
        end
    endtask

    task automatic check_ram(string tag);
        for (int w = 0; w < DEPTH; w++) begin
            if (known[w]) begin
                i_addr = 32'(w * 4 + int'($urandom_range(0, 3)));
                #1;
                chk($sformatf("%s_ram%0d", tag, w), i_data, model[w]);
            end
        end
    endtask

    task automatic check_idle_reset(string tag);
        chk({tag, "_rst_ready"}, rx_ready, 1);
        chk({tag, "_rst_core"}, core_rst_n, 0);
        chk({tag, "_rst_done"}, load_done, 0);
        chk({tag, "_rst_err"}, err, 0);
    endtask

    initial begin
        logic [7:0]  xs;
        logic [31:0] w0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        tbl[0] = '{0, 1'b1, 1'b0};
        tbl[1] = '{33, 1'b1, 1'b0};
        tbl[2] = '{255, 1'b1, 1'b0};
        tbl[3] = '{1, 1'b0, 1'b1};
        tbl[4] = '{32, 1'b0, 1'b1};
        tbl[5] = '{7, 1'b0, 1'b1};

        #12;
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            check_idle_reset($sformatf("v%0d", v));
            build(tbl[v].n);
            send_all(2);
            chk($sformatf("v%0d_err", v), err, tbl[v].exp_err);
            chk($sformatf("v%0d_done", v), load_done, tbl[v].exp_done);
            chk($sformatf("v%0d_core", v), core_rst_n, tbl[v].exp_done);
            chk($sformatf("v%0d_ready", v), rx_ready, 0);
            check_ram($sformatf("v%0d", v));
        end

        // Reference program; core reset must rise exactly with the last byte.
        do_reset();
        fq.delete();
        fq = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h63, 8'hD6, 8'h00, 8'h00};
        xs = '0;
        for (int i = 1; i < 9; i++) xs = xs ^ fq[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        fq.push_back(xs);
`endif
        for (int i = 0; i < fq.size() - 1; i++) push(fq[i], 1'b0);
        chk("prog_core_before", core_rst_n, 0);
        chk("prog_ready_before", rx_ready, 1);
        push(fq[fq.size() - 1], 1'b0);
        chk("prog_core_after", core_rst_n, 1);
        chk("prog_done_after", load_done, 1);
        chk("prog_ready_after", rx_ready, 0);
        model[0] = 32'h0050_0093;
        model[1] = 32'h0000_D663;
        known[0] = 1'b1;
        known[1] = 1'b1;
        i_addr = 32'd4;
        #1;
        chk("prog_fetch4", i_data, 32'h0000_D663);
        i_addr = 32'd0;
        #1;
        chk("prog_fetch0", i_data, 32'h0050_0093);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        fq = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        send_all(0);
        model[0] = 32'h0000_0013;
        chk("csum_bad_err", err, 1);
        chk("csum_bad_core", core_rst_n, 0);
        do_reset();
        fq = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_all(0);
        chk("csum_ok_done", load_done, 1);
        chk("csum_ok_err", err, 0);
        check_ram("csum");
`endif

        // Byte-every-other-cycle stream.
        do_reset();
        build(4);
        send_all(1);
        chk("stall_done", load_done, 1);
        check_ram("stall");

        // Reset in the middle of word 1; word 0 already written.
        do_reset();
        push(8'h02, 1'b0);
        fq.delete();
        for (int i = 0; i < 5; i++) fq.push_back(8'($urandom));
        for (int i = 0; i < 5; i++) push(fq[i], 1'b0);
        model[0] = {fq[3], fq[2], fq[1], fq[0]};
        chk("mid_done_before", load_done, 0);
        do_reset();
        check_idle_reset("mid");
        build(1);
        send_all(0);
        chk("mid_done", load_done, 1);
        w0 = model[0];
        i_addr = 32'd2;
        #1;
        chk("mid_word0", i_data, w0);
        check_ram("mid");

        // Out-of-range fetches and ignored bytes in RUN.
        build(DEPTH);
        do_reset();
        send_all(0);
        chk("run_done", load_done, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            #1;
            chk($sformatf("run_ready%0d", i), rx_ready, 0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        chk("run_done_hold", load_done, 1);
        i_addr = 32'h0000_0080;
        #1;
        chk("oor_80", i_data, 32'h0000_0013);
        i_addr = 32'hFFFF_FFFF;
        #1;
        chk("oor_top", i_data, 32'h0000_0013);
        i_addr = 32'h8000_0004;
        #1;
        chk("oor_alias", i_data, 32'h0000_0013);
        i_addr = 32'h0000_007F;
        #1;
        chk("last_word", i_data, model[DEPTH-1]);
        check_ram("run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
